// File: rtl/adxl355_reader.sv
// adxl355_reader
//   SPI mode-0 burst reader for the ADXL355 XYZ data registers. Each 1-clk
//   drdy pulse seen in IDLE starts one transaction: a read command byte
//   {start_addr[6:0],1} followed by n_data_bytes data bytes. The data bytes
//   are unpacked into three signed 20-bit axis samples.
//
// Ports
//   i_clk        system clock (40 MHz)
//   i_rst_n      asynchronous active-low reset
//   i_clk_drdy   data-ready pulse, 1 clk wide, i_clk domain
//   o_csn        SPI chip select, active low
//   o_sclk       SPI clock, CPOL=0
//   o_mosi       SPI master out
//   i_miso       SPI master in (already synchronous to i_clk)
//   o_x/o_y/o_z  signed 20-bit axis samples, held between valid strobes
//   o_valid      1-clk strobe: axis outputs updated
//   o_busy       high in every state except IDLE
//   o_overrun    1-clk pulse: a drdy arrived outside IDLE and was dropped
module adxl355_reader #(
    parameter int unsigned spi_div      = 4,
    parameter logic [7:0]  start_addr   = 8'h08,
    parameter int unsigned n_data_bytes = 9
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clk_drdy,
    output logic        o_csn,
    output logic        o_sclk,
    output logic        o_mosi,
    input  logic        i_miso,
    output logic [19:0] o_x,
    output logic [19:0] o_y,
    output logic [19:0] o_z,
    output logic        o_valid,
    output logic        o_busy,
    output logic        o_overrun
);

    localparam int unsigned N_BITS = 8 + 8 * n_data_bytes;
    localparam int unsigned DATA_W = 8 * n_data_bytes;
    localparam int unsigned PH_W   = (spi_div > 1) ? $clog2(spi_div) : 1;
    localparam int unsigned BIT_W  = $clog2(N_BITS);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(spi_div - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N_BITS - 1);
    localparam logic [BIT_W-1:0] CMD_BITS = BIT_W'(8);
    localparam logic [7:0]       CMD      = {start_addr[6:0], 1'b1};

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]        state_q,   state_d;
    logic [PH_W-1:0]   ph_q,      ph_d;
    logic              half_q,    half_d;
    logic [BIT_W-1:0]  bit_q,     bit_d;
    logic [DATA_W-1:0] data_sr_q, data_sr_d;
    logic              csn_q,     csn_d;
    logic              sclk_q,    sclk_d;
    logic              mosi_q,    mosi_d;
    logic [19:0]       x_q,       x_d;
    logic [19:0]       y_q,       y_d;
    logic [19:0]       z_q,       z_d;
    logic              valid_q,   valid_d;
    logic              busy_q,    busy_d;
    logic              overrun_q, overrun_d;
    logic              tx_bit;

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        half_d    = half_q;
        bit_d     = bit_q;
        data_sr_d = data_sr_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        overrun_d = i_clk_drdy && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (i_clk_drdy) begin
                    state_d   = ST_SETUP;
                    ph_d      = '0;
                    half_d    = 1'b0;
                    bit_d     = '0;
                    data_sr_d = '0;
                end
            end
            ST_SETUP: begin
                if (ph_q == PH_LAST) begin
                    state_d = ST_SHIFT;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                // First cycle of the high half: sclk_q is 1 right now, so this
                // is the rising-edge sample. Command-phase bits are discarded.
                if (half_q && (ph_q == '0) && (bit_q >= CMD_BITS)) begin
                    data_sr_d = {data_sr_q[DATA_W-2:0], i_miso};
                end
                if (ph_q == PH_LAST) begin
                    ph_d   = '0;
                    half_d = ~half_q;
                    if (half_q) begin
                        if (bit_q == BIT_LAST) begin
                            state_d = ST_HOLD;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (ph_q == PH_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the next-state
        // values; this keeps o_sclk/o_csn aligned with the state they belong to.
        tx_bit = (bit_d < CMD_BITS) ? CMD[3'd7 - bit_d[2:0]] : 1'b0;

        csn_d  = !((state_d == ST_SETUP) || (state_d == ST_SHIFT) ||
                   (state_d == ST_HOLD));
        sclk_d = (state_d == ST_SHIFT) && half_d;

        case (state_d)
            ST_SETUP: mosi_d = CMD[7];
            ST_SHIFT: mosi_d = (!half_d && (ph_d == '0)) ? tx_bit : mosi_q;
            default:  mosi_d = 1'b0;
        endcase

        valid_d = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);

        // Reserved low nibble of every third byte is skipped.
        if (state_d == ST_DONE) begin
            x_d = data_sr_q[DATA_W-1  -: 20];
            y_d = data_sr_q[DATA_W-25 -: 20];
            z_d = data_sr_q[DATA_W-49 -: 20];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            ph_q      <= '0;
            half_q    <= 1'b0;
            bit_q     <= '0;
            data_sr_q <= '0;
            csn_q     <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            half_q    <= half_d;
            bit_q     <= bit_d;
            data_sr_q <= data_sr_d;
            csn_q     <= csn_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_csn     = csn_q;
    assign o_sclk    = sclk_q;
    assign o_mosi    = mosi_q;
    assign o_x       = x_q;
    assign o_y       = y_q;
    assign o_z       = z_q;
    assign o_valid   = valid_q;
    assign o_busy    = busy_q;
    assign o_overrun = overrun_q;

endmodule
